clock_div_multi: RTL and testbench
==================================

// Module: clock_div_multi
// PURPOSE
//   Fully synchronous, runtime-programmable, multi-channel clock divider.
//   Each channel counts system clock cycles and produces a divided square
//   wave plus a one-cycle tick strobe, for use as a clock enable.
//   Divisors are reprogrammed through a write port. Each update is
//   glitch-free: it takes effect only at a period boundary.
//   Sits between the system clock/reset and all slow-rate logic.
//   Replaces ripple-counter division: no derived clocks, one clock domain.
// PARAMETERS
//   NUM_CH      4       number of independent divider channels (>=1)
//   DIV_W       18      divisor / counter width in bits
//   DEFAULT_DIV 131072  divisor loaded into every channel at reset (2^17)
//   CH_W        derived localparam = max(1, clog2(NUM_CH)); not overridable
// PORTS
//   clock      in   1        system clock, all logic on rising edge
//   reset      in   1        synchronous, active-high
//   en         in   NUM_CH   per-channel run enable
//   sync       in   1        restart all channels phase-aligned
//   wr_en      in   1        divisor write strobe
//   wr_ch      in   CH_W     target channel of write
//   wr_div     in   DIV_W    new divisor value
//   div_clock  out  NUM_CH   divided square wave per channel (registered)
//   tick       out  NUM_CH   1-cycle strobe, once per period (registered)
//   pending    out  NUM_CH   shadow divisor written but not yet active
// BEHAVIOUR
//   - Per channel: shadow divisor S, active divisor A, counter cnt (DIV_W bits).
//   - Effective divisor N = max(A, 2). The clamp is applied at load, so A never holds 0 or 1.
//   - Reset: cnt=0, div_clock=0, tick=0, pending=0, S=A=max(DEFAULT_DIV,2).
//   - Write: wr_en && wr_ch<NUM_CH -> S[wr_ch] <= wr_div, and pending set next cycle.
//     A write with wr_ch>=NUM_CH is ignored.
//   - Run (en[c]=1, no sync):
//       if cnt==N-1 -> cnt<=0, tick<=1, A<=clamp(S), pending<=0
//       else        -> cnt<=cnt+1, tick<=0
//   - div_clock <= (cnt_next >= N/2), where N/2 truncates.
//     Result: low floor(N/2) cycles, high ceil(N/2) cycles.
//     Rising edge is mid-period; falling edge coincides with tick.
//   - Period is exactly N clocks. Tick and div_clock edges are 1 cycle after the counter value.
//   - Disabled (en[c]=0): cnt<=0, div_clock<=0, tick<=0, A<=clamp(S), pending<=0.
//     Re-enable starts a fresh period.
//   - sync=1: all channels cnt<=0, div_clock<=0, tick<=0, A<=clamp(S), pending<=0,
//     regardless of en.
//   - Priority: reset > sync > en=0 > wrap > count.
//   - Write and load of the same channel in the same cycle: the load takes the old S.
//     The new S is stored and pending stays 1 until the next boundary.
//   - The counter never exceeds N-1. There is no other wrap-around path.
//   - Max divisor is 2^DIV_W-1.
//   - Reset mid-period: all state returns to reset values on the next edge.
//     No partial tick is produced.
// STRUCTURE
//   - Package clock_div_pkg:
//       localparam MIN_DIV=2
//       function clog2
//       function clamp_div(DIV_W-bit) -> max(x, MIN_DIV)
//   - Sub-module clock_div_chan: one channel (S, A, cnt, outputs, pending).
//     Inputs: load strobe, en, sync, write data.
//   - Top: write decode, range check, generate loop of NUM_CH channels.
// TESTING
//   1. reset, write ch0 div=4, sync, en[0]=1
//      -> div_clock[0] = 0,0,1,1 repeating; tick[0] every 4th cycle,
//         aligned with the falling edge.
//   2. div=5 -> div_clock low 2 / high 3 cycles; tick period 5; pending 1 only until first wrap.
//   3. write div=0, then div=1, each followed by sync
//      -> both behave as N=2: div_clock toggles every cycle, tick every 2.
//   4. A=8 running, write 3 at cnt=2
//      -> the current period still lasts 8 cycles, then periods of 3;
//         pending=1 from the cycle after the write until the boundary.
//   5. write ch1 on the same cycle ch1 wraps -> the old S loads and pending stays 1;
//      wr_ch=NUM_CH has no effect on any channel.
//   6. reset at cnt=5, and separately en drop mid-period
//      -> outputs 0 next cycle; after reset S=A=DEFAULT_DIV; re-enable gives a full first period.

Source files
------------

// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Pure constants/functions: no latency, no backpressure.
package clock_div_pkg;

  localparam int MIN_DIV = 2;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Divisors below 2 cannot form a square wave; they run as divide-by-2.
  function automatic logic [31:0] clamp_div(input logic [31:0] x);
    return (x < 32'(MIN_DIV)) ? 32'(MIN_DIV) : x;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: shadow/active divisor, period counter, registered outputs.
// Latency: outputs register one cycle after the counter value they reflect.
// Backpressure: none; writes are always accepted into the shadow divisor.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int DIV_W       = 18,
  parameter int DEFAULT_DIV = 131072
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             div_clock,
  output logic             tick,
  output logic             pending
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

  logic [DIV_W-1:0] shadow_q;
  logic [DIV_W-1:0] active_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_nxt;
  logic             restart;
  logic             wrap;
  logic             boundary;

  // active_q is clamped at load time, so active_q-1 never underflows.
  always_comb begin
    restart  = sync || !en;
    wrap     = (cnt_q == (active_q - 1'b1));
    boundary = restart || wrap;
    cnt_nxt  = boundary ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q  <= RST_DIV;
      active_q  <= RST_DIV;
      cnt_q     <= '0;
      div_clock <= 1'b0;
      tick      <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_q <= wr_div;
      end
      // A load in the same cycle as a write still picks up the old shadow.
      if (boundary) begin
        active_q <= DIV_W'(clamp_div(32'(shadow_q)));
      end
      cnt_q     <= cnt_nxt;
      tick      <= !restart && wrap;
      div_clock <= !restart && (cnt_nxt >= (active_q >> 1));
      if (wr_en) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock-enable generator with glitch-free divisor updates.
// Latency: tick/div_clock registered; a written divisor applies at the next period boundary.
// Backpressure: none; out-of-range channel writes are dropped.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = 18,
  parameter  int DEFAULT_DIV = 131072,
  localparam int CH_W        = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] div_clock,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic wr_hit;

  // wr_ch can encode more values than there are channels when NUM_CH is not a power of two.
  assign wr_hit = wr_en && (32'(wr_ch) < 32'(NUM_CH));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic ch_wr;

    assign ch_wr = wr_hit && (wr_ch == CH_W'(c));

    clock_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .en        (en[c]),
      .sync      (sync),
      .wr_en     (ch_wr),
      .wr_div    (wr_div),
      .div_clock (div_clock[c]),
      .tick      (tick[c]),
      .pending   (pending[c])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Randomized bench for clock_div_multi against a per-channel period/phase model.
module tb_clock_div_multi;

  localparam int NCH   = 3;
  localparam int DW    = 18;
  localparam int DEF   = 12;
  localparam int CHW   = 2;

  logic           clock;
  logic           reset;
  logic [NCH-1:0] en;
  logic           sync;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [DW-1:0]  wr_div;
  logic [NCH-1:0] div_clock;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  clock_div_multi #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .sync      (sync),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_div    (wr_div),
    .div_clock (div_clock),
    .tick      (tick),
    .pending   (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: shadow, active period, elapsed cycles in the current period.
  int m_s[NCH];
  int m_a[NCH];
  int m_e[NCH];
  int m_pend[NCH];
  int m_tick[NCH];
  int m_dclk[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int clampd(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        m_s[c] = clampd(DEF); m_a[c] = clampd(DEF); m_e[c] = 0;
        m_pend[c] = 0; m_tick[c] = 0; m_dclk[c] = 0;
      end else begin
        bit running;
        bit period_end;
        running    = !sync && en[c];
        period_end = 1'b0;
        if (running) begin
          m_e[c]     = (m_e[c] + 1) % m_a[c];
          period_end = (m_e[c] == 0);
        end else begin
          m_e[c] = 0;
        end
        m_tick[c] = (running && period_end) ? 1 : 0;
        if (!running || period_end) begin
          m_a[c]    = clampd(m_s[c]);
          m_pend[c] = 0;
        end
        if (wr_en && int'(wr_ch) == c && int'(wr_ch) < NCH) begin
          m_s[c]    = int'(wr_div);
          m_pend[c] = 1;
        end
        m_dclk[c] = (running && m_e[c] >= m_a[c] / 2) ? 1 : 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("div_clock%0d", c), 32'(div_clock[c]), 32'(m_dclk[c]));
      check($sformatf("tick%0d", c),      32'(tick[c]),      32'(m_tick[c]));
      check($sformatf("pending%0d", c),   32'(pending[c]),   32'(m_pend[c]));
    end
  endtask

  task automatic write(input int ch, input int val);
    wr_en  = 1'b1;
    wr_ch  = CHW'(ch);
    wr_div = DW'(val);
    cycle();
    wr_en  = 1'b0;
  endtask

  task automatic do_sync();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
  endtask

  initial begin
    int pat_dc[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int pat_tk[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int guard;

    reset = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    cycle(); cycle();
    check("rst_outputs", 32'({div_clock, tick, pending}), 32'd0);
    reset = 1'b0;

    // Divide by 4 from a synced start.
    write(0, 4);
    check("t1_pending_after_write", 32'(pending[0]), 32'd1);
    do_sync();
    check("t1_pending_after_sync", 32'(pending[0]), 32'd0);
    en = 3'b001;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("t1_dc_%0d", i), 32'(div_clock[0]), 32'(pat_dc[i]));
      check($sformatf("t1_tk_%0d", i), 32'(tick[0]), 32'(pat_tk[i]));
    end

    // Odd divisor takes effect at the next wrap.
    write(0, 5);
    repeat (15) cycle();

    // Degenerate divisors clamp to 2.
    write(0, 0); do_sync(); repeat (6) cycle();
    write(0, 1); do_sync(); repeat (6) cycle();

    // Mid-period rewrite of a running divide-by-8.
    write(1, 8); do_sync(); en = 3'b011;
    cycle(); cycle();
    write(1, 3);
    repeat (20) cycle();

    // Write landing on the wrap edge keeps pending.
    guard = 0;
    while (!(m_e[1] == m_a[1] - 1) && guard < 50) begin
      cycle();
      guard++;
    end
    check("t5_wrap_found", 32'(guard < 50), 32'd1);
    write(1, 6);
    check("t5_tick_on_write", 32'(tick[1]), 32'd1);
    check("t5_pending_kept", 32'(pending[1]), 32'd1);
    cycle();
    check("t5_pending_still", 32'(pending[1]), 32'd1);
    write(3, 2);
    check("t5_oob_no_pending", 32'(pending[2]), 32'd0);
    repeat (12) cycle();

    // Reset and enable drop mid-period.
    write(2, 10); do_sync(); en = 3'b111;
    repeat (5) cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    check("t6_reset_outputs", 32'({div_clock, tick, pending}), 32'd0);
    repeat (30) cycle();
    repeat (4) cycle();
    en = 3'b000; cycle();
    check("t6_disable_outputs", 32'({div_clock, tick}), 32'd0);
    en = 3'b111;
    repeat (15) cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 15) != 0);
      sync  = ($urandom_range(0, 63) == 0);
      reset = ($urandom_range(0, 299) == 0);
      wr_en = ($urandom_range(0, 5) == 0);
      wr_ch = CHW'($urandom_range(0, 3));
      wr_div = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(0, 300))
                                            : DW'($urandom_range(0, 12));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
